mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the CPU's single synchronous memory port between the instruction-fetch path and the load/store path, so LDR/STR can execute on the same memory the fetch stage uses. It is a registered-output arbiter with one outstanding access at a time. It uses fixed data-over-instruction priority with a starvation guard, and supports variable-latency memory through a `mem_ready` handshake. It sits between `fetch_instruction`, the load/store sequencing in the controller, and the memory model.

## Interface
- `AW`, 32: address width.
- `DW`, 32: data width.
- `MAX_D_STREAK`, 4: consecutive D grants allowed while `i_req` is pending before I is forced. Legal range 1..15.
- `TIMEOUT`, 15: ACCESS cycles without `mem_ready` before abort. Legal range 1..255. Used only with `MEM_ARB_TIMEOUT_EN`.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `i_req`  in  1  fetch request; hold until `i_gnt`.
- `i_addr`  in  AW  fetch address.
- `i_gnt`  out  1  one-cycle grant pulse to fetch.
- `i_rvalid`  out  1  one-cycle completion pulse; `i_rdata` is valid in this cycle.
- `i_rdata`  out  DW  fetched word.
- `i_err`  out  1  one-cycle abort pulse.
- `d_req`, `d_we`  in  1 each  load/store request and write enable.
- `d_addr`  in  AW  load/store address.
- `d_wdata`  in  DW  store data.
- `d_be`  in  4  store byte enables.
- `d_gnt`, `d_rvalid`, `d_err`  out  1 each  same semantics as the I side; `d_rvalid` also acknowledges stores.
- `d_rdata`  out  DW  load data.
- `mem_en`, `mem_we`  out  1 each  memory strobe and write enable.
- `mem_addr`  out  AW  memory address.
- `mem_wdata`  out  DW  memory write data.
- `mem_be`  out  4  memory byte enables.
- `mem_ready`  in  1  access done this cycle.
- `mem_rdata`  in  DW  read data, valid when `mem_ready`=1.
- `busy`  out  1  high while in ACCESS.

## Operation
- FSM has two states, IDLE and ACCESS. Requests are sampled only in IDLE.
- IDLE behaviour:
  - If either request is high, pick the owner, latch its address/we/wdata/be into the `mem_*` registers, set `owner`, go to ACCESS, and assert the owner's `gnt` for exactly the first ACCESS cycle.
  - Requests arriving while in ACCESS are held off and re-evaluated on the return to IDLE.
- Priority rule: D wins, except I wins when `streak == MAX_D_STREAK` and `i_req`=1.
- Streak counter:
  - Increments, saturating, on each D grant made while `i_req`=1.
  - Cleared on an I grant, and on a D grant made while `i_req`=0.
- I accesses always drive `mem_we`=0 and `mem_be`=4'hF.
- ACCESS behaviour:
  - `mem_en`=1, and all `mem_*` outputs stay stable.
  - When `mem_ready`=1: if the access is a read, capture `mem_rdata` into the owner's rdata register; pulse the owner's rvalid in the next cycle; return to IDLE.
- rdata registers update only on read completion. A store completion leaves `d_rdata` unchanged.
- `mem_ready` outside ACCESS is ignored.
- Reset values: all outputs 0, state IDLE, streak 0, timeout counter 0.
- Reset mid-ACCESS: `mem_en` drops immediately (asynchronous). No rvalid or err is produced, and the in-flight access is lost.

## Timing
- Cycle 0: request high in IDLE.
- Cycle 1: `gnt`=1, `mem_en`=1, `busy`=1.
- First cycle with `mem_ready`=1 is cycle k, where k≥1.
- Cycle k+1: rvalid=1 and rdata valid; FSM is back in IDLE and may grant again.
- Zero-wait throughput is one access per 2 cycles. Load-to-use latency is k+1.
- The requester may deassert `req` in the `gnt` cycle. If `req` is still high in cycle k+1, it is treated as a new request.
- rvalid and err are mutually exclusive, and each lasts exactly one cycle.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - An 8-bit counter counts ACCESS cycles.
  - If `mem_ready` is still 0 in the `TIMEOUT`-th ACCESS cycle, the FSM drops `mem_en` and returns to IDLE. The owner's err pulses in the next cycle; rvalid does not pulse and rdata is unchanged.
  - If `mem_ready`=1 in that same cycle, ready wins.
- `MEM_ARB_TIMEOUT_EN` undefined: ACCESS waits indefinitely, the counter is removed, and `i_err`/`d_err` are tied to 0.

## Test plan
- I only, zero-wait: `i_req`=1, `i_addr`=0x100, `mem_ready`=1 in cycle 1, `mem_rdata`=0xE3A01005 → `i_gnt` in cycle 1, `mem_addr`=0x100, `i_rvalid`=1 with `i_rdata`=0xE3A01005 in cycle 2.
- Simultaneous requests: `d_req`/`d_we`=1, `d_addr`=0x200, `d_wdata`=0x12345678, `d_be`=0xF, together with `i_req` → `d_gnt` first, `mem_we`=1, `d_rvalid` pulse; then `i_gnt` on the next IDLE cycle.
- Starvation guard: both requests held high continuously, `MAX_D_STREAK`=4 → grant sequence D,D,D,D,I,D,D,D,D,I.
- Wait states: `mem_ready` rises 3 cycles after grant → `mem_*` outputs are stable for 4 cycles, `busy`=1 throughout, rvalid is exactly 1 cycle after ready, no grant occurs during ACCESS.
- Timeout, macro on, `TIMEOUT`=15: `mem_ready` held 0 → `i_err` pulses in cycle 16 with no `i_rvalid`, then the next request is served normally. Macro off: `busy` stays 1 after 100 cycles.
- Reset in ACCESS cycle 2 → `mem_en`, `busy`, and `gnt` go to 0 immediately, with no rvalid or err. After release, `i_req`=1 is served with the cycle-1/cycle-2 timing of the first scenario.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, load/store and memory-side signals of the
// shared memory port arbiter.
// The arbiter uses the master modport because it masters the memory bus and
// answers both requesters. The slave modport is the requester/memory side.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // Instruction-fetch side
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt;
    logic          i_rvalid;
    logic [DW-1:0] i_rdata;
    logic          i_err;

    // Load/store side
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [3:0]    d_be;
    logic          d_gnt;
    logic          d_rvalid;
    logic          d_err;
    logic [DW-1:0] d_rdata;

    // Memory side
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_be;
    logic          mem_ready;
    logic [DW-1:0] mem_rdata;

    logic          busy;

    modport master (
        input  i_req, i_addr,
        output i_gnt, i_rvalid, i_rdata, i_err,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        output d_gnt, d_rvalid, d_err, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ready, mem_rdata,
        output busy
    );

    modport slave (
        output i_req, i_addr,
        input  i_gnt, i_rvalid, i_rdata, i_err,
        output d_req, d_we, d_addr, d_wdata, d_be,
        input  d_gnt, d_rvalid, d_err, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ready, mem_rdata,
        input  busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the CPU's single synchronous memory port between
// instruction fetch (I) and load/store (D). All outputs are registered, and
// only one access is outstanding at a time. D has priority over I. After
// MAX_D_STREAK back-to-back D grants with I waiting, I gets the port.
// Memory latency can vary; completion is signalled by mem_ready.
// Optional feature macro: MEM_ARB_TIMEOUT_EN. When it is defined, an access
// without mem_ready for TIMEOUT cycles is aborted and the owner gets an err
// pulse.
module mem_port_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 15
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.master bus
);

    if (MAX_D_STREAK < 1 || MAX_D_STREAK > 15) begin : g_bad_streak
        $error("mem_port_arbiter: MAX_D_STREAK must be 1..15");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("mem_port_arbiter: TIMEOUT must be 1..255");
    end

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_grant_i;
    logic          w_grant_d;
    logic          w_done;
    logic [3:0]    w_streak_nxt;

    logic [3:0]    r_streak;
    logic          r_owner_d;
    logic          r_i_gnt;
    logic          r_d_gnt;
    logic          r_i_rvalid;
    logic          r_d_rvalid;
    logic [DW-1:0] r_i_rdata;
    logic [DW-1:0] r_d_rdata;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic [3:0]    r_mem_be;

`ifdef MEM_ARB_TIMEOUT_EN
    logic          w_abort;
    logic [7:0]    r_tcnt;
    logic          r_i_err;
    logic          r_d_err;
`endif

    // Next state, grant choice and streak update. Requests are only looked at in IDLE.
    always_comb begin
        w_state_nxt  = r_state;
        w_grant_i    = 1'b0;
        w_grant_d    = 1'b0;
        w_done       = 1'b0;
        w_streak_nxt = r_streak;
`ifdef MEM_ARB_TIMEOUT_EN
        w_abort      = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (bus.i_req && (!bus.d_req || (r_streak == 4'(MAX_D_STREAK)))) begin
                    w_grant_i    = 1'b1;
                    w_streak_nxt = 4'd0;
                    w_state_nxt  = S_ACCESS;
                end else if (bus.d_req) begin
                    w_grant_d    = 1'b1;
                    // Only D wins that actually made I wait count toward the streak
                    if (bus.i_req)
                        w_streak_nxt = (r_streak == 4'hF) ? r_streak : r_streak + 4'd1;
                    else
                        w_streak_nxt = 4'd0;
                    w_state_nxt  = S_ACCESS;
                end
            end
            S_ACCESS: begin
                // A ready in the last allowed cycle still completes normally
                if (bus.mem_ready) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (r_tcnt == 8'(TIMEOUT - 1)) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                end
`endif
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register; async reset kills any in-flight access at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Grant/completion pulses, memory command latch and read-data capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_streak    <= 4'd0;
            r_owner_d   <= 1'b0;
            r_i_gnt     <= 1'b0;
            r_d_gnt     <= 1'b0;
            r_i_rvalid  <= 1'b0;
            r_d_rvalid  <= 1'b0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= 4'h0;
        end else begin
            r_streak   <= w_streak_nxt;
            r_i_gnt    <= w_grant_i;
            r_d_gnt    <= w_grant_d;
            r_i_rvalid <= w_done && !r_owner_d;
            r_d_rvalid <= w_done &&  r_owner_d;
            if (w_grant_i) begin
                // Fetches are always full-word reads
                r_owner_d   <= 1'b0;
                r_mem_addr  <= bus.i_addr;
                r_mem_we    <= 1'b0;
                r_mem_wdata <= '0;
                r_mem_be    <= 4'hF;
            end else if (w_grant_d) begin
                r_owner_d   <= 1'b1;
                r_mem_addr  <= bus.d_addr;
                r_mem_we    <= bus.d_we;
                r_mem_wdata <= bus.d_wdata;
                r_mem_be    <= bus.d_be;
            end
            // Stores complete without touching the load data register
            if (w_done && !r_mem_we) begin
                if (r_owner_d) r_d_rdata <= bus.mem_rdata;
                else           r_i_rdata <= bus.mem_rdata;
            end
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    // ACCESS-cycle counter (holds n-1 in the n-th ACCESS cycle) and abort pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tcnt  <= 8'd0;
            r_i_err <= 1'b0;
            r_d_err <= 1'b0;
        end else begin
            if (r_state == S_ACCESS && w_state_nxt == S_ACCESS) r_tcnt <= r_tcnt + 8'd1;
            else                                                 r_tcnt <= 8'd0;
            r_i_err <= w_abort && !r_owner_d;
            r_d_err <= w_abort &&  r_owner_d;
        end
    end

    assign bus.i_err = r_i_err;
    assign bus.d_err = r_d_err;
`else
    assign bus.i_err = 1'b0;
    assign bus.d_err = 1'b0;
`endif

    assign bus.i_gnt     = r_i_gnt;
    assign bus.i_rvalid  = r_i_rvalid;
    assign bus.i_rdata   = r_i_rdata;
    assign bus.d_gnt     = r_d_gnt;
    assign bus.d_rvalid  = r_d_rvalid;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.mem_en    = (r_state == S_ACCESS);
    assign bus.busy      = (r_state == S_ACCESS);
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_be    = r_mem_be;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios for the shared memory port arbiter,
// followed by randomized fetch/load/store traffic. The traffic is checked
// against a transaction-level reference model with a memory array.
module tb_mem_port_arbiter;
    localparam int AW           = 32;
    localparam int DW           = 32;
    localparam int MAX_D_STREAK = 4;
    localparam int TIMEOUT      = 15;
    localparam int RAND_CYCLES  = 3000;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fails  = 0;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus();

    mem_port_arbiter #(
        .AW(AW), .DW(DW), .MAX_D_STREAK(MAX_D_STREAK), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Single zero-wait fetch: grant in cycle 1, data in cycle 2.
    task automatic i_zero_wait(input logic [31:0] a, input logic [31:0] d);
        bus.i_req  = 1'b1;
        bus.i_addr = a;
        @(negedge clk);
        chk("zw_i_gnt",    bus.i_gnt,    1);
        chk("zw_d_gnt",    bus.d_gnt,    0);
        chk("zw_mem_en",   bus.mem_en,   1);
        chk("zw_busy",     bus.busy,     1);
        chk("zw_mem_addr", bus.mem_addr, a);
        chk("zw_mem_we",   bus.mem_we,   0);
        chk("zw_mem_be",   bus.mem_be,   4'hF);
        bus.i_req     = 1'b0;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = d;
        @(negedge clk);
        chk("zw_i_rvalid", bus.i_rvalid, 1);
        chk("zw_i_rdata",  bus.i_rdata,  d);
        chk("zw_i_gnt_2",  bus.i_gnt,    0);
        chk("zw_i_err",    bus.i_err,    0);
        chk("zw_busy_2",   bus.busy,     0);
        bus.mem_ready = 1'b0;
        @(negedge clk);
        chk("zw_i_rvalid_3", bus.i_rvalid, 0);
    endtask

    // Reference model state for the random phase
    logic [31:0] tb_mem [256];
    bit          m_acc;
    bit          m_own_d;
    bit          m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_be;
    int          m_wait;
    int          m_streak;
    logic [31:0] m_i_rdata;
    logic [31:0] m_d_rdata;
    bit          e_i_gnt, e_d_gnt, e_i_rv, e_d_rv;

    initial begin
        logic [9:0] seq;
        int         ng;
        bit         grant_i;

        rst           = 1'b1;
        bus.i_req     = 1'b0;
        bus.i_addr    = '0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.d_be      = 4'h0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_i_gnt",     bus.i_gnt,     0);
        chk("rst_d_gnt",     bus.d_gnt,     0);
        chk("rst_i_rvalid",  bus.i_rvalid,  0);
        chk("rst_d_rvalid",  bus.d_rvalid,  0);
        chk("rst_i_rdata",   bus.i_rdata,   0);
        chk("rst_d_rdata",   bus.d_rdata,   0);
        chk("rst_mem_en",    bus.mem_en,    0);
        chk("rst_mem_we",    bus.mem_we,    0);
        chk("rst_mem_addr",  bus.mem_addr,  0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_mem_be",    bus.mem_be,    0);
        chk("rst_busy",      bus.busy,      0);
        chk("rst_errs",      {bus.i_err, bus.d_err}, 0);
        rst = 1'b0;
        @(negedge clk);

        // I only, zero-wait
        i_zero_wait(32'h100, 32'hE3A0_1005);

        // Simultaneous requests: D store first, then I
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h200;
        bus.d_wdata = 32'h1234_5678;
        bus.d_be    = 4'hF;
        bus.i_req   = 1'b1;
        bus.i_addr  = 32'h104;
        @(negedge clk);
        chk("sim_d_gnt",     bus.d_gnt,     1);
        chk("sim_i_gnt",     bus.i_gnt,     0);
        chk("sim_mem_we",    bus.mem_we,    1);
        chk("sim_mem_addr",  bus.mem_addr,  32'h200);
        chk("sim_mem_wdata", bus.mem_wdata, 32'h1234_5678);
        chk("sim_mem_be",    bus.mem_be,    4'hF);
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("sim_d_rvalid",  bus.d_rvalid, 1);
        chk("sim_i_rvalid",  bus.i_rvalid, 0);
        chk("sim_d_rdata",   bus.d_rdata,  0);
        chk("sim_i_gnt_2",   bus.i_gnt,    0);
        bus.mem_ready = 1'b0;
        @(negedge clk);
        chk("sim_i_gnt_3",   bus.i_gnt,    1);
        chk("sim_mem_addr2", bus.mem_addr, 32'h104);
        chk("sim_mem_we2",   bus.mem_we,   0);
        chk("sim_d_rvalid2", bus.d_rvalid, 0);
        bus.i_req     = 1'b0;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h0000_A5A5;
        @(negedge clk);
        chk("sim_i_rvalid2", bus.i_rvalid, 1);
        chk("sim_i_rdata",   bus.i_rdata,  32'h0000_A5A5);
        bus.mem_ready = 1'b0;
        @(negedge clk);

        // Starvation guard: both held, zero-wait memory
        bus.i_req     = 1'b1;
        bus.i_addr    = 32'h80;
        bus.d_req     = 1'b1;
        bus.d_we      = 1'b0;
        bus.d_addr    = 32'h84;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = '0;
        seq = '0;
        ng  = 0;
        for (int c = 0; c < 40 && ng < 10; c++) begin
            @(negedge clk);
            if (bus.i_gnt || bus.d_gnt) begin
                chk("starve_one_gnt", bus.i_gnt & bus.d_gnt, 0);
                seq = {seq[8:0], bus.d_gnt};
                ng++;
            end
        end
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        chk("starve_count", ng, 10);
        chk("starve_seq",   seq, 10'b11110_11110);
        @(negedge clk);
        bus.mem_ready = 1'b0;
        @(negedge clk);

        // Wait states: load, mem_ready 3 cycles after grant, I request held off
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h300;
        @(negedge clk);
        chk("ws_d_gnt",    bus.d_gnt,    1);
        chk("ws_mem_addr", bus.mem_addr, 32'h300);
        chk("ws_busy",     bus.busy,     1);
        bus.d_req  = 1'b0;
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h120;
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            chk("ws_no_gnt",    {bus.i_gnt, bus.d_gnt}, 0);
            chk("ws_busy_n",    bus.busy,     1);
            chk("ws_mem_en_n",  bus.mem_en,   1);
            chk("ws_addr_n",    bus.mem_addr, 32'h300);
            chk("ws_we_n",      bus.mem_we,   0);
            chk("ws_be_n",      bus.mem_be,   4'hF);
            chk("ws_rvalid_n",  bus.d_rvalid, 0);
        end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        chk("ws_d_rvalid", bus.d_rvalid, 1);
        chk("ws_d_rdata",  bus.d_rdata,  32'hCAFE_F00D);
        chk("ws_busy_end", bus.busy,     0);
        chk("ws_i_gnt_0",  bus.i_gnt,    0);
        bus.mem_ready = 1'b0;
        @(negedge clk);
        chk("ws_i_gnt",     bus.i_gnt,    1);
        chk("ws_d_rvalid2", bus.d_rvalid, 0);
        chk("ws_i_addr",    bus.mem_addr, 32'h120);
        bus.i_req     = 1'b0;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h1122_3344;
        @(negedge clk);
        chk("ws_i_rvalid", bus.i_rvalid, 1);
        chk("ws_i_rdata",  bus.i_rdata,  32'h1122_3344);
        bus.mem_ready = 1'b0;
        @(negedge clk);

`ifdef MEM_ARB_TIMEOUT_EN
        // Timeout: no ready, err in cycle TIMEOUT+1, then normal service
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h40;
        @(negedge clk);
        chk("to_gnt",  bus.i_gnt, 1);
        chk("to_busy", bus.busy,  1);
        bus.i_req = 1'b0;
        for (int c = 2; c <= TIMEOUT; c++) begin
            @(negedge clk);
            chk("to_busy_n",   bus.busy,     1);
            chk("to_err_n",    bus.i_err,    0);
            chk("to_rvalid_n", bus.i_rvalid, 0);
        end
        @(negedge clk);
        chk("to_err",    bus.i_err,    1);
        chk("to_rvalid", bus.i_rvalid, 0);
        chk("to_busy_e", bus.busy,     0);
        chk("to_mem_en", bus.mem_en,   0);
        chk("to_rdata",  bus.i_rdata,  32'h1122_3344);
        @(negedge clk);
        chk("to_err_off", bus.i_err, 0);
        i_zero_wait(32'h44, 32'h5A5A_0001);
`else
        // No timeout: access waits indefinitely
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h40;
        @(negedge clk);
        chk("nt_gnt", bus.i_gnt, 1);
        bus.i_req = 1'b0;
        repeat (100) @(negedge clk);
        chk("nt_busy",   bus.busy,     1);
        chk("nt_err",    bus.i_err,    0);
        chk("nt_rvalid", bus.i_rvalid, 0);
        do_reset();
`endif

        // Reset in ACCESS cycle 2
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h48;
        @(negedge clk);
        chk("ra_gnt", bus.i_gnt, 1);
        bus.i_req = 1'b0;
        @(negedge clk);
        chk("ra_busy_pre", bus.busy, 1);
        rst = 1'b1;
        #1;
        chk("ra_mem_en", bus.mem_en, 0);
        chk("ra_busy",   bus.busy,   0);
        chk("ra_gnt_0",  {bus.i_gnt, bus.d_gnt}, 0);
        chk("ra_rv_err", {bus.i_rvalid, bus.i_err}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("ra_post_rv",   bus.i_rvalid, 0);
            chk("ra_post_err",  bus.i_err,    0);
            chk("ra_post_busy", bus.busy,     0);
        end
        i_zero_wait(32'h4C, 32'h0F0F_1234);

        // Randomized traffic against the reference model
        for (int i = 0; i < 256; i++) tb_mem[i] = $urandom();
        m_acc     = 1'b0;
        m_own_d   = 1'b0;
        m_we      = 1'b0;
        m_addr    = '0;
        m_wdata   = '0;
        m_be      = 4'h0;
        m_wait    = 0;
        m_streak  = 0;
        m_i_rdata = 32'h0F0F_1234;
        m_d_rdata = 32'h0;
        e_i_gnt   = 1'b0;
        e_d_gnt   = 1'b0;
        e_i_rv    = 1'b0;
        e_d_rv    = 1'b0;
        for (int n = 0; n < RAND_CYCLES; n++) begin
            @(negedge clk);
            chk("rnd_i_gnt",    bus.i_gnt,    e_i_gnt);
            chk("rnd_d_gnt",    bus.d_gnt,    e_d_gnt);
            chk("rnd_i_rvalid", bus.i_rvalid, e_i_rv);
            chk("rnd_d_rvalid", bus.d_rvalid, e_d_rv);
            chk("rnd_i_rdata",  bus.i_rdata,  m_i_rdata);
            chk("rnd_d_rdata",  bus.d_rdata,  m_d_rdata);
            chk("rnd_busy",     bus.busy,     m_acc);
            chk("rnd_mem_en",   bus.mem_en,   m_acc);
            chk("rnd_errs",     {bus.i_err, bus.d_err}, 0);
            if (m_acc) begin
                chk("rnd_mem_addr", bus.mem_addr, m_addr);
                chk("rnd_mem_we",   bus.mem_we,   m_we);
                chk("rnd_mem_be",   bus.mem_be,   m_be);
                if (m_we) chk("rnd_mem_wdata", bus.mem_wdata, m_wdata);
            end

            // Requesters: drop in the grant cycle, occasionally raise a new one
            if (e_i_gnt) bus.i_req = 1'b0;
            if (e_d_gnt) bus.d_req = 1'b0;
            if (!bus.i_req && $urandom_range(0, 2) == 0) begin
                bus.i_req  = 1'b1;
                bus.i_addr = 32'($urandom_range(0, 255)) << 2;
            end
            if (!bus.d_req && $urandom_range(0, 2) == 0) begin
                bus.d_req   = 1'b1;
                bus.d_we    = 1'($urandom_range(0, 1));
                bus.d_addr  = 32'($urandom_range(0, 255)) << 2;
                bus.d_wdata = $urandom();
                bus.d_be    = 4'($urandom_range(1, 15));
            end

            // Memory: ready after the chosen number of wait cycles, noise otherwise
            bus.mem_rdata = $urandom();
            if (m_acc && m_wait == 0) begin
                bus.mem_ready = 1'b1;
                if (!m_we) bus.mem_rdata = tb_mem[m_addr[9:2]];
            end else begin
                bus.mem_ready = m_acc ? 1'b0 : 1'($urandom_range(0, 1));
                if (m_acc) m_wait--;
            end

            // What the next cycle must show
            e_i_gnt = 1'b0;
            e_d_gnt = 1'b0;
            e_i_rv  = 1'b0;
            e_d_rv  = 1'b0;
            if (m_acc) begin
                if (bus.mem_ready) begin
                    if (m_own_d) e_d_rv = 1'b1;
                    else         e_i_rv = 1'b1;
                    if (!m_we) begin
                        if (m_own_d) m_d_rdata = bus.mem_rdata;
                        else         m_i_rdata = bus.mem_rdata;
                    end else begin
                        for (int b = 0; b < 4; b++)
                            if (m_be[b]) tb_mem[m_addr[9:2]][8*b +: 8] = m_wdata[8*b +: 8];
                    end
                    m_acc = 1'b0;
                end
            end else if (bus.i_req || bus.d_req) begin
                grant_i = bus.i_req && (!bus.d_req || m_streak == MAX_D_STREAK);
                if (grant_i) begin
                    e_i_gnt  = 1'b1;
                    m_own_d  = 1'b0;
                    m_addr   = bus.i_addr;
                    m_we     = 1'b0;
                    m_be     = 4'hF;
                    m_wdata  = '0;
                    m_streak = 0;
                end else begin
                    e_d_gnt  = 1'b1;
                    m_own_d  = 1'b1;
                    m_addr   = bus.d_addr;
                    m_we     = bus.d_we;
                    m_be     = bus.d_be;
                    m_wdata  = bus.d_wdata;
                    m_streak = bus.i_req ? m_streak + 1 : 0;
                end
                m_acc  = 1'b1;
                m_wait = $urandom_range(0, 3);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
